processor_stage2: RTL
=====================

Name: processor_stage2

Overview:
- Decode/operand stage of the 18-bit pipelined processor.
- Takes the instruction word and ip from the fetch stage and reads two operands from the register file, forwarding from the write port driven by stage3.
- Computes ry+imm8 and issues the data-memory address/write, then registers the operand bundle consumed by processor_stage3.
- Accepts stage3's call_performed as a pipeline flush.

Parameters:
- ADDR_SIZE, 18, width of ip and memory address.
- WORD_SIZE, 18, width of data words and code_word.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch stage presents a valid instruction this cycle.
- in_code_word  input  WORD_SIZE  instruction from fetch.
- in_ip  input  ADDR_SIZE  address of in_code_word.
- stall  input  1  freeze this stage: output registers hold, no memory write.
- rf_read_addr0  output  3  register file read port 0 address = rx field.
- rf_read_addr1  output  3  register file read port 1 address = ry field.
- rf_read_data0  input  WORD_SIZE  combinational read data, port 0.
- rf_read_data1  input  WORD_SIZE  combinational read data, port 1.
- reg_write_enable  input  1  stage3 write port, used for forwarding.
- reg_write_addr  input  3  stage3 write address.
- reg_write_data  input  WORD_SIZE  stage3 write data.
- call_performed  input  1  stage3 redirect; flush.
- mem_addr  output  ADDR_SIZE  data memory address (synchronous-read memory).
- mem_write_enable  output  1  data memory write strobe.
- mem_write_data  output  WORD_SIZE  data memory write data.
- no_operation  output  1  registered; stage3 must ignore the bundle.
- alu_data0  output  WORD_SIZE  registered rx operand.
- alu_data1  output  WORD_SIZE  registered ry operand.
- data1_plus_imm8  output  WORD_SIZE  registered ry + sext(imm8).
- code_word  output  WORD_SIZE  registered instruction.
- ip  output  ADDR_SIZE  registered in_ip.
- ip_plus_one  output  ADDR_SIZE  registered in_ip+1.

Behaviour:
- Fields:
  - opcode = code_word[17:14]
  - rx = [13:11]
  - ry = [10:8]
  - imm8 = [7:0], sign-extended to WORD_SIZE
- Operands:
  - op0 = (reg_write_enable && reg_write_addr==rx) ? reg_write_data : rf_read_data0.
  - op1 is formed the same way on ry.
  - Forwarding is purely combinational and applies to all registers, including r0.
- sum = op1 + sext(imm8), modulo 2^WORD_SIZE. mem_addr = sum[ADDR_SIZE-1:0], driven every cycle regardless of opcode.
- accept = in_valid && !stall && !call_performed.
- mem_write_enable = accept && opcode==OP_WRITE_TO_MEMORY. mem_write_data = op0 (the forwarded rx).
- OP_LOAD_FROM_MEMORY needs no extra action. The memory registers the address and memory_out appears in the next cycle, aligned with the instruction in stage3.
- Output register update on posedge clock:
  - call_performed=1: no_operation<=1, other outputs hold. Flush has priority over stall and in_valid.
  - Else stall=1: all outputs hold.
  - Else in_valid=0: no_operation<=1, other outputs hold.
  - Else: no_operation<=0; alu_data0<=op0; alu_data1<=op1; data1_plus_imm8<=sum; code_word<=in_code_word; ip<=in_ip; ip_plus_one<=in_ip+1 (wraps 2^ADDR_SIZE-1 -> 0).
- Latency:
  - One cycle from in_* to the stage3 bundle.
  - mem_write_enable is combinational in the accept cycle.
- Reset (asynchronous) forces:
  - no_operation=1
  - alu_data0, alu_data1, data1_plus_imm8, code_word, ip, ip_plus_one = 0
- mem_write_enable is combinational and already gated by the inputs. The bench keeps in_valid=0 during reset.
- Reset mid-operation discards the held instruction. No memory write occurs while in_valid=0.
- Opcodes not listed here pass through unchanged; stage3 interprets them.

Test Plan:
- Reset, then release with in_valid=0 -> no_operation=1, all data outputs 0, mem_write_enable=0.
- Forwarding on OP_REG_ADD_IMM8:
  - Stimulus: rx=2, ry=3, imm8=0xFE, rf_read_data1=10, stage3 writing r3=100.
  - Expect: next cycle alu_data1=100, data1_plus_imm8=98, mem_addr=98 in the accept cycle.
  - Repeat without the stage3 write -> data1_plus_imm8=8.
- OP_WRITE_TO_MEMORY, rx=1 (rf=0x2AAAA), ry=4 (rf=0x3FFFF), imm8=0x02:
  - mem_write_enable=1, mem_addr=0x00001 (wrap), mem_write_data=0x2AAAA in the same cycle.
- call_performed=1 with a valid OP_WRITE_TO_MEMORY presented:
  - mem_write_enable=0; next cycle no_operation=1; ip/code_word unchanged.
- stall=1 for 3 cycles with a valid instruction, then 0:
  - Outputs hold their previous bundle.
  - The instruction is captured only on the first non-stall edge, and any memory write is issued only in that cycle.
- in_ip=0x3FFFF accepted -> ip=0x3FFFF, ip_plus_one=0x00000. Reset asserted mid-stream -> no_operation=1 immediately, asynchronously.

Source files
------------

// File: rtl/processor_stage2_if.sv
// Signal bundle between processor_stage2 and its neighbours (fetch, register
// file, data memory and stage3). The stage uses the slave view.
interface processor_stage2_if #(
    parameter int unsigned ADDR_SIZE = 18,
    parameter int unsigned WORD_SIZE = 18
);
    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_code_word;
    logic [ADDR_SIZE-1:0] in_ip;
    logic                 stall;
    logic [2:0]           rf_read_addr0;
    logic [2:0]           rf_read_addr1;
    logic [WORD_SIZE-1:0] rf_read_data0;
    logic [WORD_SIZE-1:0] rf_read_data1;
    logic                 reg_write_enable;
    logic [2:0]           reg_write_addr;
    logic [WORD_SIZE-1:0] reg_write_data;
    logic                 call_performed;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_write_enable;
    logic [WORD_SIZE-1:0] mem_write_data;
    logic                 no_operation;
    logic [WORD_SIZE-1:0] alu_data0;
    logic [WORD_SIZE-1:0] alu_data1;
    logic [WORD_SIZE-1:0] data1_plus_imm8;
    logic [WORD_SIZE-1:0] code_word;
    logic [ADDR_SIZE-1:0] ip;
    logic [ADDR_SIZE-1:0] ip_plus_one;

    modport slave (
        input  in_valid, in_code_word, in_ip, stall, rf_read_data0, rf_read_data1,
               reg_write_enable, reg_write_addr, reg_write_data, call_performed,
        output rf_read_addr0, rf_read_addr1, mem_addr, mem_write_enable, mem_write_data,
               no_operation, alu_data0, alu_data1, data1_plus_imm8, code_word, ip,
               ip_plus_one
    );

    modport master (
        output in_valid, in_code_word, in_ip, stall, rf_read_data0, rf_read_data1,
               reg_write_enable, reg_write_addr, reg_write_data, call_performed,
        input  rf_read_addr0, rf_read_addr1, mem_addr, mem_write_enable, mem_write_data,
               no_operation, alu_data0, alu_data1, data1_plus_imm8, code_word, ip,
               ip_plus_one
    );
endinterface

// File: rtl/processor_stage2.sv
// Decode/operand stage: reads rx/ry with stage3 write-port forwarding, drives the
// data-memory address/write, and registers the operand bundle for stage3.
module processor_stage2 #(
    parameter int unsigned ADDR_SIZE = 18,
    parameter int unsigned WORD_SIZE = 18
) (
    input logic              clock,
    input logic              reset,
    processor_stage2_if.slave bus
);
    localparam logic [3:0] OP_REG_ADD_IMM8     = 4'h2;
    localparam logic [3:0] OP_LOAD_FROM_MEMORY = 4'h6;
    localparam logic [3:0] OP_WRITE_TO_MEMORY  = 4'h7;
    localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = 1;

    logic [3:0]           opcode;
    logic [2:0]           rx;
    logic [2:0]           ry;
    logic [7:0]           imm8;
    logic [WORD_SIZE-1:0] imm_sext;
    logic [WORD_SIZE-1:0] op0;
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] sum;
    logic                 accept;

    logic                 no_operation_q;
    logic [WORD_SIZE-1:0] alu_data0_q;
    logic [WORD_SIZE-1:0] alu_data1_q;
    logic [WORD_SIZE-1:0] data1_plus_imm8_q;
    logic [WORD_SIZE-1:0] code_word_q;
    logic [ADDR_SIZE-1:0] ip_q;
    logic [ADDR_SIZE-1:0] ip_plus_one_q;

    assign opcode   = bus.in_code_word[17:14];
    assign rx       = bus.in_code_word[13:11];
    assign ry       = bus.in_code_word[10:8];
    assign imm8     = bus.in_code_word[7:0];
    assign imm_sext = {{(WORD_SIZE-8){imm8[7]}}, imm8};

    // Forward stage3's pending write, r0 included.
    assign op0 = (bus.reg_write_enable && bus.reg_write_addr == rx) ?
                 bus.reg_write_data : bus.rf_read_data0;
    assign op1 = (bus.reg_write_enable && bus.reg_write_addr == ry) ?
                 bus.reg_write_data : bus.rf_read_data1;
    assign sum = op1 + imm_sext;

    assign accept = bus.in_valid && !bus.stall && !bus.call_performed;

    assign bus.rf_read_addr0    = rx;
    assign bus.rf_read_addr1    = ry;
    assign bus.mem_addr         = sum[ADDR_SIZE-1:0];
    assign bus.mem_write_enable = accept && (opcode == OP_WRITE_TO_MEMORY);
    assign bus.mem_write_data   = op0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            no_operation_q    <= 1'b1;
            alu_data0_q       <= '0;
            alu_data1_q       <= '0;
            data1_plus_imm8_q <= '0;
            code_word_q       <= '0;
            ip_q              <= '0;
            ip_plus_one_q     <= '0;
        end else if (bus.call_performed) begin
            no_operation_q <= 1'b1;
        end else if (bus.stall) begin
            no_operation_q <= no_operation_q;
        end else if (!bus.in_valid) begin
            no_operation_q <= 1'b1;
        end else begin
            no_operation_q    <= 1'b0;
            alu_data0_q       <= op0;
            alu_data1_q       <= op1;
            data1_plus_imm8_q <= sum;
            code_word_q       <= bus.in_code_word;
            ip_q              <= bus.in_ip;
            ip_plus_one_q     <= bus.in_ip + ONE_ADDR;
        end
    end

    assign bus.no_operation    = no_operation_q;
    assign bus.alu_data0       = alu_data0_q;
    assign bus.alu_data1       = alu_data1_q;
    assign bus.data1_plus_imm8 = data1_plus_imm8_q;
    assign bus.code_word       = code_word_q;
    assign bus.ip              = ip_q;
    assign bus.ip_plus_one     = ip_plus_one_q;
endmodule
